// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types, states and BCD digit adder for score_keeper
package score_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [3:0] score_t;

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT} state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Returns {carry_out, digit}; an out-of-range award digit counts as 9.
  function automatic logic [4:0] bcd_add_digit(input bcd_digit_t a, input bcd_digit_t b,
                                               input logic cin);
    bcd_digit_t b_c;
    logic [4:0] sum;
    b_c = (b > 4'd9) ? 4'd9 : b;
    sum = {1'b0, a} + {1'b0, b_c} + {4'd0, cin};
    if (sum >= 5'd10) return {1'b1, 4'(sum - 5'd10)};
    return {1'b0, sum[3:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker searching upward from i_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [PW-1:0]      o_winner_idx,
  output logic               o_valid
);

  int         w_pos;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_winner     = '0;
    o_winner_idx = '0;
    o_valid      = 1'b0;
    w_pos        = 0;
    w_idx        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_pos = int'(i_ptr) + off;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_idx = PW'(w_pos);
      if (!o_valid && i_req[w_idx]) begin
        o_valid         = 1'b1;
        o_winner[w_idx] = 1'b1;
        o_winner_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - arbitrated digit-serial BCD score accumulator with frame-synced display
module score_keeper
  import score_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   i_clear,
  input  logic                   i_frame_sync,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_pts_bcd,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic [3:0]             o_thousands,
  output logic [3:0]             o_hundreds,
  output logic [3:0]             o_tens,
  output logic [3:0]             o_ones
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  score_t               r_work;
  score_t               r_committed;
  score_t               r_award;
  score_t               r_disp;
  logic                 r_carry;
  logic                 r_overflow;
  logic [PW-1:0]        r_rr_ptr;
  logic [NUM_REQ-1:0]   r_grant;

  logic [NUM_REQ-1:0]   w_winner;
  logic [PW-1:0]        w_winner_idx;
  logic                 w_valid;
  logic [1:0]           w_dig;
  logic [4:0]           w_sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .i_req        (i_req),
    .i_ptr        (r_rr_ptr),
    .o_winner     (w_winner),
    .o_winner_idx (w_winner_idx),
    .o_valid      (w_valid)
  );

  always_comb begin
    w_dig = 2'd0;
    case (r_state)
      ADD1:    w_dig = 2'd1;
      ADD2:    w_dig = 2'd2;
      ADD3:    w_dig = 2'd3;
      default: w_dig = 2'd0;
    endcase
  end

  assign w_sum = bcd_add_digit(r_work[w_dig], r_award[w_dig], r_carry);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_committed <= '0;
      r_award     <= '0;
      r_disp      <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
    end else begin
      r_grant <= '0;
      if (i_frame_sync) r_disp <= r_committed;
      // Clear wins over everything, including the display load and any grant.
      if (i_clear) begin
        r_state     <= IDLE;
        r_work      <= '0;
        r_committed <= '0;
        r_disp      <= '0;
        r_carry     <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_valid) begin
              r_award  <= i_pts_bcd[16*w_winner_idx +: 16];
              r_grant  <= w_winner;
              r_carry  <= 1'b0;
              r_rr_ptr <= (w_winner_idx == PW'(NUM_REQ - 1)) ? '0 : w_winner_idx + 1'b1;
              r_state  <= ADD0;
            end
          end
          ADD0, ADD1, ADD2: begin
            r_work[w_dig] <= w_sum[3:0];
            r_carry       <= w_sum[4];
            r_state       <= (r_state == ADD0) ? ADD1 : (r_state == ADD1) ? ADD2 : ADD3;
          end
          ADD3: begin
            if (w_sum[4]) begin
              r_work     <= BCD_MAX;
              r_overflow <= 1'b1;
            end else begin
              r_work[3] <= w_sum[3:0];
            end
            r_carry <= 1'b0;
            r_state <= COMMIT;
          end
          COMMIT: begin
            r_committed <= r_work;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_grant     = r_grant;
  assign o_busy      = (r_state != IDLE);
  assign o_overflow  = r_overflow;
  assign o_thousands = r_disp[3];
  assign o_hundreds  = r_disp[2];
  assign o_tens      = r_disp[1];
  assign o_ones      = r_disp[0];

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized self-checking bench for score_keeper against a decimal model
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        frame = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] pts = '0;
  logic [3:0]  grant;
  logic        busy, ovf;
  logic [3:0]  th, hu, te, on;

  score_keeper #(.NUM_REQ(4)) dut (
    .Clk(clk), .Reset(rst), .i_clear(clear), .i_frame_sync(frame),
    .i_req(req), .i_pts_bcd(pts), .o_grant(grant), .o_busy(busy), .o_overflow(ovf),
    .o_thousands(th), .o_hundreds(hu), .o_tens(te), .o_ones(on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Decimal model of the score, displayed value, sticky overflow and arbitration pointer
  int m_score, m_disp, m_ovf, m_ptr;
  logic [15:0] pts_tab [4];
  int got_idx[$];
  int got_cyc[$];
  bit serve_to;

  function automatic int clamp_val(input logic [15:0] p);
    int v, d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {th, hu, te, on};
  endfunction

  function automatic int exp_next(input logic [3:0] pend, input int ptr);
    for (int off = 0; off < 4; off++)
      if (pend[(ptr + off) % 4]) return (ptr + off) % 4;
    return -1;
  endfunction

  task automatic model_add(input logic [15:0] p);
    m_score = m_score + clamp_val(p);
    if (m_score > 9999) begin
      m_score = 9999;
      m_ovf = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; frame = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_score = 0; m_disp = 0; m_ovf = 0; m_ptr = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_score = 0; m_disp = 0; m_ovf = 0;
  endtask

  task automatic do_frame();
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    m_disp = m_score;
  endtask

  // Single award from one requester; reports grant vector, grant width and busy length.
  task automatic grant_award(input int idx, input logic [15:0] p, output int gvec,
                             output int gwidth, output int bcount, output bit tout);
    pts[16*idx +: 16] = p;
    req[idx] = 1'b1;
    tout = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        tout = 1'b0;
        break;
      end
    end
    req[idx] = 1'b0;
    gvec = int'(grant);
    gwidth = (grant != 0) ? 1 : 0;
    bcount = busy ? 1 : 0;
    if (!tout) begin
      model_add(p);
      m_ptr = (idx + 1) % 4;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant != 0) gwidth++;
      if (busy) bcount++;
    end
  endtask

  // Raises every requester in mask with pts_tab awards and records grant order and timing.
  task automatic serve_mask(input logic [3:0] mask);
    int cyc;
    logic [3:0] pend;
    got_idx.delete();
    got_cyc.delete();
    for (int j = 0; j < 4; j++) pts[16*j +: 16] = pts_tab[j];
    pend = mask;
    req = mask;
    cyc = 0;
    while (pend != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (grant != 0) begin
        for (int j = 0; j < 4; j++)
          if (grant[j]) begin
            got_idx.push_back(j);
            got_cyc.push_back(cyc);
            pend[j] = 1'b0;
          end
        req = pend;
      end
    end
    serve_to = (pend != 0);
    req = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (shown() !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: disp=%h ovf=%b busy=%b, want 0000/0/0", shown(), ovf, busy);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000) begin
        errors++;
        $display("FAIL reset_no_grant: grant=%b, want 0000", grant);
      end
    end
  endtask

  task automatic test_repeat();
    int gv, gw, bc;
    bit to;
    for (int n = 0; n < 3; n++) begin
      grant_award(1, 16'h0250, gv, gw, bc, to);
      do_frame();
      checks++;
      if (to || gv !== 2 || gw !== 1 || bc !== 5) begin
        errors++;
        $display("FAIL repeat_grant[%0d]: to=%0d gvec=%0d width=%0d busy=%0d, want 0/2/1/5", n, to, gv, gw, bc);
      end
      checks++;
      if (shown() !== to_bcd(m_disp)) begin
        errors++;
        $display("FAIL repeat_disp[%0d]: disp=%h, want %h", n, shown(), to_bcd(m_disp));
      end
    end
  endtask

  task automatic test_ripple();
    int gv, gw, bc;
    bit to;
    do_clear();
    grant_award(0, 16'h0995, gv, gw, bc, to);
    grant_award(0, 16'h0005, gv, gw, bc, to);
    do_frame();
    checks++;
    if (shown() !== to_bcd(m_disp) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ripple: disp=%h ovf=%b, want %h/0", shown(), ovf, to_bcd(m_disp));
    end
  endtask

  task automatic test_saturate();
    int gv, gw, bc;
    bit to;
    do_clear();
    grant_award(2, 16'h9990, gv, gw, bc, to);
    grant_award(2, 16'h0020, gv, gw, bc, to);
    do_frame();
    checks++;
    if (shown() !== to_bcd(m_disp) || ovf !== 1'(m_ovf)) begin
      errors++;
      $display("FAIL saturate: disp=%h ovf=%b, want %h/%0d", shown(), ovf, to_bcd(m_disp), m_ovf);
    end
    do_clear();
    checks++;
    if (shown() !== 16'h0000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_sat: disp=%h ovf=%b, want 0000/0", shown(), ovf);
    end
  endtask

  task automatic test_clamp();
    int gv, gw, bc;
    bit to;
    grant_award(3, 16'h0F0F, gv, gw, bc, to);
    do_frame();
    checks++;
    if (shown() !== to_bcd(m_disp)) begin
      errors++;
      $display("FAIL clamp: disp=%h, want %h", shown(), to_bcd(m_disp));
    end
  endtask

  task automatic test_round_robin();
    int p, e;
    logic [3:0] pend;
    do_reset();
    for (int j = 0; j < 4; j++) pts_tab[j] = 16'h0001;
    for (int pass = 0; pass < 2; pass++) begin
      pend = (pass == 0) ? 4'b1111 : 4'b1001;
      serve_mask(pend);
      checks++;
      if (serve_to || got_idx.size() != $countones(pend)) begin
        errors++;
        $display("FAIL rr_count[%0d]: timeout=%0d grants=%0d, want 0/%0d", pass, serve_to, got_idx.size(), $countones(pend));
      end
      p = m_ptr;
      for (int k = 0; k < got_idx.size(); k++) begin
        e = exp_next(pend, p);
        checks++;
        if (got_idx[k] != e) begin
          errors++;
          $display("FAIL rr_order[%0d.%0d]: got %0d, want %0d", pass, k, got_idx[k], e);
        end
        if (k > 0) begin
          checks++;
          if (got_cyc[k] - got_cyc[k-1] != 6) begin
            errors++;
            $display("FAIL rr_spacing[%0d.%0d]: got %0d, want 6", pass, k, got_cyc[k] - got_cyc[k-1]);
          end
        end
        if (e >= 0) begin
          pend[e] = 1'b0;
          p = (e + 1) % 4;
          model_add(pts_tab[e]);
        end
      end
      m_ptr = p;
      if (pass == 0) begin
        do_frame();
        checks++;
        if (shown() !== to_bcd(m_disp)) begin
          errors++;
          $display("FAIL rr_disp: disp=%h, want %h", shown(), to_bcd(m_disp));
        end
      end
    end
  endtask

  task automatic test_commit_frame();
    int old;
    bit to;
    old = m_score;
    pts[0 +: 16] = 16'h0007;
    req[0] = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        to = 1'b0;
        break;
      end
    end
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    checks++;
    if (to || shown() !== to_bcd(old)) begin
      errors++;
      $display("FAIL commit_frame_old: to=%0d disp=%h, want %h", to, shown(), to_bcd(old));
    end
    model_add(16'h0007);
    m_ptr = 1;
    do_frame();
    checks++;
    if (shown() !== to_bcd(m_disp)) begin
      errors++;
      $display("FAIL commit_frame_new: disp=%h, want %h", shown(), to_bcd(m_disp));
    end
  endtask

  task automatic test_clear_mid();
    int extra;
    bit to;
    pts[32 +: 16] = 16'h0123;
    req[2] = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        to = 1'b0;
        break;
      end
    end
    req[2] = 1'b0;
    m_ptr = 3;
    repeat (2) @(negedge clk);
    do_clear();
    checks++;
    if (to || shown() !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_state: to=%0d disp=%h busy=%b, want 0000/0", to, shown(), busy);
    end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant != 0) extra++;
    end
    do_frame();
    checks++;
    if (extra != 0 || shown() !== 16'h0000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_after: regrants=%0d disp=%h ovf=%b, want 0/0000/0", extra, shown(), ovf);
    end
  endtask

  task automatic test_clear_with_req();
    pts[16 +: 16] = 16'h0042;
    req[1] = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_score = 0; m_disp = 0; m_ovf = 0;
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL clear_req_suppress: grant=%b, want 0000", grant);
    end
    @(negedge clk);
    req[1] = 1'b0;
    checks++;
    if (grant !== 4'(1 << exp_next(4'b0010, m_ptr))) begin
      errors++;
      $display("FAIL clear_req_next: grant=%b, want 0010", grant);
    end
    model_add(16'h0042);
    m_ptr = 2;
    repeat (8) @(negedge clk);
    do_frame();
    checks++;
    if (shown() !== to_bcd(m_disp)) begin
      errors++;
      $display("FAIL clear_req_disp: disp=%h, want %h", shown(), to_bcd(m_disp));
    end
  endtask

  task automatic test_random();
    logic [3:0] mask, pend;
    int p, e;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) do_clear();
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) pts_tab[j] = 16'($urandom);
      serve_mask(mask);
      pend = mask;
      p = m_ptr;
      checks++;
      if (serve_to || got_idx.size() != $countones(mask)) begin
        errors++;
        $display("FAIL rand_count[%0d]: timeout=%0d grants=%0d, want 0/%0d", it, serve_to, got_idx.size(), $countones(mask));
      end
      for (int k = 0; k < got_idx.size(); k++) begin
        e = exp_next(pend, p);
        checks++;
        if (got_idx[k] != e) begin
          errors++;
          $display("FAIL rand_order[%0d.%0d]: got %0d, want %0d", it, k, got_idx[k], e);
        end
        if (e >= 0) begin
          pend[e] = 1'b0;
          p = (e + 1) % 4;
          model_add(pts_tab[e]);
        end
      end
      m_ptr = p;
      do_frame();
      checks++;
      if (shown() !== to_bcd(m_disp) || ovf !== 1'(m_ovf)) begin
        errors++;
        $display("FAIL rand_disp[%0d]: disp=%h ovf=%b, want %h/%0d", it, shown(), ovf, to_bcd(m_disp), m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_repeat();
    test_ripple();
    test_saturate();
    test_clamp();
    test_round_robin();
    test_commit_frame();
    test_clear_mid();
    test_clear_with_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
